// File: rtl/debounce_sync.sv
// ----------------------------------------------------------------------------
// debounce_sync
//   Input conditioning ahead of the d-capture flip-flop. The raw, asynchronous
//   and possibly bouncy d_in is synchronized through a flop chain. A new
//   level is accepted only after the synchronized signal has held it for
//   STABLE_CYCLES+1 consecutive cycles. The result is a clean registered
//   level q, its complement qbar, and single-cycle rise/fall event pulses.
//
//   Parameters
//     SYNC_STAGES    synchronizer depth (>= 2)
//     STABLE_CYCLES  extra consecutive cycles a new level must hold (>= 1)
//     CNT_W          qualification counter width, 2**CNT_W > STABLE_CYCLES-1
//
//   Ports
//     clk    in   single clock, all logic on posedge
//     rst_n  in   synchronous reset, active-low
//     d_in   in   raw asynchronous input
//     q      out  debounced, synchronized level (registered)
//     qbar   out  ~q
//     rise   out  one-cycle pulse in the cycle q first shows 1 (registered)
//     fall   out  one-cycle pulse in the cycle q first shows 0 (registered)
//     busy   out  high while a new level is being qualified (registered)
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   STABLE_LO | q = 0 and the synchronized input agrees
//   CHECK_HI  | synchronized input went 1, counting toward acceptance
//   STABLE_HI | q = 1 and the synchronized input agrees
//   CHECK_LO  | synchronized input went 0, counting toward acceptance
// ----------------------------------------------------------------------------
module debounce_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic q,
   output logic qbar,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHECK_HI  = 2'd1,
      STABLE_HI = 2'd2,
      CHECK_LO  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             q_nx;
   logic             rise_nx;
   logic             fall_nx;
   logic             busy_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= STABLE_LO;
         cnt   <= '0;
         q     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         q     <= q_nx;
         rise  <= rise_nx;
         fall  <= fall_nx;
         busy  <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      q_nx     = q;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      case (state)
         STABLE_LO: begin
            if (sync) begin
               state_nx = CHECK_HI;
               cnt_nx   = '0;
            end
         end
         CHECK_HI: begin
            if (!sync) begin
               // bounce back to the old level: drop the candidate entirely
               state_nx = STABLE_LO;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx = STABLE_HI;
               cnt_nx   = '0;
               q_nx     = 1'b1;
               rise_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         STABLE_HI: begin
            if (!sync) begin
               state_nx = CHECK_LO;
               cnt_nx   = '0;
            end
         end
         CHECK_LO: begin
            if (sync) begin
               state_nx = STABLE_HI;
               cnt_nx   = '0;
            end else if (cnt == CNT_MAX) begin
               state_nx = STABLE_LO;
               cnt_nx   = '0;
               q_nx     = 1'b0;
               fall_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = STABLE_LO;
            cnt_nx   = '0;
            q_nx     = 1'b0;
         end
      endcase
      // busy is registered from the next state so it lines up with state
      busy_nx = (state_nx == CHECK_HI) || (state_nx == CHECK_LO);
   end

   assign qbar = ~q;

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic d_a;
   logic d_b;
   logic q_a, qbar_a, rise_a, fall_a, busy_a;
   logic q_b, qbar_b, rise_b, fall_b, busy_b;

   debounce_sync dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (d_a),
      .q     (q_a),
      .qbar  (qbar_a),
      .rise  (rise_a),
      .fall  (fall_a),
      .busy  (busy_a)
   );

   debounce_sync #(
      .SYNC_STAGES   (3),
      .STABLE_CYCLES (1),
      .CNT_W         (3)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (d_b),
      .q     (q_b),
      .qbar  (qbar_b),
      .rise  (rise_b),
      .fall  (fall_b),
      .busy  (busy_b)
   );

   typedef struct {
      string tag;
      logic  q;
      logic  rise;
      logic  fall;
      logic  busy;
      bit    chk_busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   sel      = 0;
   int   rise_cnt = 0;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected outputs for n edges after a stimulus change (edge 1 = first
   // edge sampling the new d level). q starts at q0 and flips at chg_at
   // (0 = never), with the matching pulse on that edge only; busy is high
   // on edges b_from..b_to.
   task automatic push_seg(input string tag, input int n, input logic q0,
                           input int b_from, input int b_to, input int chg_at,
                           input bit chk_busy);
      for (int k = 1; k <= n; k++) begin
         exp_t e;
         e.tag      = $sformatf("%s[%0d]", tag, k);
         e.q        = (chg_at != 0 && k >= chg_at) ? ~q0 : q0;
         e.rise     = (k == chg_at) && !q0;
         e.fall     = (k == chg_at) && q0;
         e.busy     = (k >= b_from) && (k <= b_to);
         e.chk_busy = chk_busy;
         exp_q.push_back(e);
      end
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         logic o_q, o_qb, o_r, o_f, o_b;
         @(posedge clk);
         #1;
         o_q  = (sel != 0) ? q_b    : q_a;
         o_qb = (sel != 0) ? qbar_b : qbar_a;
         o_r  = (sel != 0) ? rise_b : rise_a;
         o_f  = (sel != 0) ? fall_b : fall_a;
         o_b  = (sel != 0) ? busy_b : busy_a;
         if (sel == 0 && rise_a === 1'b1) rise_cnt++;
         if (exp_q.size() == 0) begin
            chk_int("sb_underflow", 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk({e.tag, " q"}, o_q, e.q);
            chk({e.tag, " qbar"}, o_qb, ~e.q);
            chk({e.tag, " rise"}, o_r, e.rise);
            chk({e.tag, " fall"}, o_f, e.fall);
            if (e.chk_busy) chk({e.tag, " busy"}, o_b, e.busy);
            chk({e.tag, " rise_and_fall"}, o_r & o_f, 1'b0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      d_a   = 1'b1;
      d_b   = 1'b0;

      // reset held with d_in high, then release: q rises at edge 7
      push_seg("reset", 3, 1'b0, 0, 0, 0, 1'b1);
      run_ticks(3);
      rst_n = 1'b1;
      push_seg("rel_rise", 7, 1'b0, 3, 6, 7, 1'b1);
      run_ticks(7);
      push_seg("hold_hi1", 3, 1'b1, 0, 0, 0, 1'b1);
      run_ticks(3);

      // clean steps both directions
      push_seg("fall1", 7, 1'b1, 3, 6, 7, 1'b1);
      d_a = 1'b0;
      run_ticks(7);
      push_seg("hold_lo1", 3, 1'b0, 0, 0, 0, 1'b1);
      run_ticks(3);
      push_seg("rise2", 7, 1'b0, 3, 6, 7, 1'b1);
      d_a = 1'b1;
      run_ticks(7);
      push_seg("hold_hi2", 3, 1'b1, 0, 0, 0, 1'b1);
      run_ticks(3);
      push_seg("fall2", 7, 1'b1, 3, 6, 7, 1'b1);
      d_a = 1'b0;
      run_ticks(7);
      push_seg("hold_lo2", 3, 1'b0, 0, 0, 0, 1'b1);
      run_ticks(3);

      // 4-cycle pulse is rejected
      push_seg("glitch4", 10, 1'b0, 3, 6, 0, 1'b1);
      d_a = 1'b1;
      run_ticks(4);
      d_a = 1'b0;
      run_ticks(6);

      // 5-cycle pulse is accepted, then its trailing edge is accepted too
      push_seg("acc5_rise", 7, 1'b0, 3, 6, 7, 1'b1);
      push_seg("acc5_fall", 5, 1'b1, 1, 4, 5, 1'b1);
      d_a = 1'b1;
      run_ticks(5);
      d_a = 1'b0;
      run_ticks(7);
      push_seg("hold_lo3", 3, 1'b0, 0, 0, 0, 1'b1);
      run_ticks(3);

      // bounce train 1,0,1,0,1 then held high: one rise, 7 edges after final 0->1
      rise_cnt = 0;
      push_seg("bounce_pre", 4, 1'b0, 0, 0, 0, 1'b0);
      push_seg("bounce", 7, 1'b0, 0, 0, 7, 1'b0);
      d_a = 1'b1; run_ticks(1);
      d_a = 1'b0; run_ticks(1);
      d_a = 1'b1; run_ticks(1);
      d_a = 1'b0; run_ticks(1);
      d_a = 1'b1; run_ticks(7);
      push_seg("hold_hi3", 3, 1'b1, 0, 0, 0, 1'b1);
      run_ticks(3);
      chk_int("bounce_rise_count", rise_cnt, 1);
      push_seg("fall3", 7, 1'b1, 3, 6, 7, 1'b1);
      d_a = 1'b0;
      run_ticks(7);
      push_seg("hold_lo4", 3, 1'b0, 0, 0, 0, 1'b1);
      run_ticks(3);

      // reset sampled at edge 5 of a pending rise abandons it
      push_seg("rst_pre", 4, 1'b0, 3, 4, 0, 1'b1);
      d_a = 1'b1;
      run_ticks(4);
      rst_n = 1'b0;
      push_seg("rst_mid", 1, 1'b0, 0, 0, 0, 1'b1);
      run_ticks(1);
      rst_n = 1'b1;
      push_seg("rst_post", 7, 1'b0, 3, 6, 7, 1'b1);
      run_ticks(7);
      push_seg("hold_hi4", 3, 1'b1, 0, 0, 0, 1'b1);
      run_ticks(3);
      push_seg("fall4", 7, 1'b1, 3, 6, 7, 1'b1);
      d_a = 1'b0;
      run_ticks(7);

      // SYNC_STAGES=3, STABLE_CYCLES=1 instance
      sel = 1;
      push_seg("b_rise", 5, 1'b0, 4, 4, 5, 1'b1);
      d_b = 1'b1;
      run_ticks(5);
      push_seg("b_hold_hi", 2, 1'b1, 0, 0, 0, 1'b1);
      run_ticks(2);
      push_seg("b_fall", 5, 1'b1, 4, 4, 5, 1'b1);
      d_b = 1'b0;
      run_ticks(5);
      push_seg("b_hold_lo", 2, 1'b0, 0, 0, 0, 1'b1);
      run_ticks(2);
      push_seg("b_glitch1", 6, 1'b0, 4, 4, 0, 1'b1);
      d_b = 1'b1;
      run_ticks(1);
      d_b = 1'b0;
      run_ticks(5);
      push_seg("b_acc2_rise", 5, 1'b0, 4, 4, 5, 1'b1);
      push_seg("b_acc2_fall", 2, 1'b1, 1, 1, 2, 1'b1);
      d_b = 1'b1;
      run_ticks(2);
      d_b = 1'b0;
      run_ticks(5);
      push_seg("b_hold_lo2", 3, 1'b0, 0, 0, 0, 1'b1);
      run_ticks(3);

      chk_int("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
